// File: rtl/hook_collision_detector_pkg.sv
// hook_collision_detector_pkg: shared game constants and hook state encoding
package hook_collision_detector_pkg;
    localparam int NUM_OBJECTS            = 8;
    localparam int IDX_W                  = $clog2(NUM_OBJECTS);
    localparam int TIMEOUT_FRAMES_DEFAULT = 90;
    typedef enum logic [1:0] {IDLE, ARMED, HOOKED} state_t;
endpackage

// File: rtl/priority_encoder_lowest.sv
// priority_encoder_lowest: index of the lowest set request bit plus any-set flag
module priority_encoder_lowest #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);
    // scan from the top down so the lowest set bit is written last
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) o_idx = i_req[i] ? W'(i) : o_idx;
    end
    assign o_valid = |i_req;
endmodule

// File: rtl/hook_collision_detector.sv
// hook_collision_detector: one collision pulse per cable launch, object capture and collection tracking
module hook_collision_detector
    import hook_collision_detector_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_startOfFrame,
    input  logic                   i_launch_Cable,
    input  logic                   i_cableHome,
    input  logic                   i_drawingRequest_hook,
    input  logic [NUM_OBJECTS-1:0] i_drawingRequest_objects,
    input  logic                   i_drawingRequest_border,
    output logic                   o_collision,
    output logic                   o_hitObjectValid,
    output logic [IDX_W-1:0]       o_hitObjectIdx,
    output logic [NUM_OBJECTS-1:0] o_collectedMask,
    output logic                   o_collectPulse,
    output logic [IDX_W-1:0]       o_collectIdx
);
    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_collision;
    logic                   r_hit_valid;
    logic [IDX_W-1:0]       r_hit_idx;
    logic [NUM_OBJECTS-1:0] r_mask;
    logic                   r_collect_pulse;
    logic [IDX_W-1:0]       r_collect_idx;
    logic [NUM_OBJECTS-1:0] w_eff;
    logic [IDX_W-1:0]       w_enc_idx;
    logic                   w_enc_valid;
    logic                   w_obj_hit;
    logic                   w_border_hit;
    logic                   w_timeout;
    logic                   w_fire;
    logic                   w_collect;

    assign w_eff        = i_drawingRequest_objects & ~r_mask;
    assign w_obj_hit    = i_drawingRequest_hook & w_enc_valid;
    assign w_border_hit = i_drawingRequest_hook & i_drawingRequest_border;
    assign w_timeout    = i_startOfFrame && (r_cnt == CNT_W'(TIMEOUT_FRAMES - 1));

    priority_encoder_lowest #(.N(NUM_OBJECTS), .W(IDX_W)) u_enc (
        .i_req   (w_eff),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // next state plus the one-shot fire and collect decisions
    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_collect    = 1'b0;
        case (r_state)
            IDLE:    w_next_state = i_launch_Cable ? ARMED : IDLE;
            ARMED: begin
                w_fire       = w_obj_hit | w_border_hit | w_timeout;
                w_next_state = w_fire ? HOOKED : ARMED;
            end
            HOOKED: begin
                w_collect    = i_cableHome & r_hit_valid;
                w_next_state = i_cableHome ? IDLE : HOOKED;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // registered outputs, frame timeout counter and collected-object bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt           <= '0;
            r_collision     <= 1'b0;
            r_hit_valid     <= 1'b0;
            r_hit_idx       <= '0;
            r_mask          <= '0;
            r_collect_pulse <= 1'b0;
            r_collect_idx   <= '0;
        end else begin
            r_collision     <= w_fire;
            r_collect_pulse <= w_collect;
            if (r_state == IDLE && i_launch_Cable) r_cnt <= '0;
            else if (r_state == ARMED && i_startOfFrame && !w_fire) r_cnt <= r_cnt + 1'b1;
            if (w_fire) begin
                r_hit_valid <= w_obj_hit;
                if (w_obj_hit) r_hit_idx <= w_enc_idx;
            end
            if (w_collect) begin
                r_hit_valid   <= 1'b0;
                r_collect_idx <= r_hit_idx;
                r_mask        <= r_mask | (NUM_OBJECTS'(1) << r_hit_idx);
            end
        end
    end

    assign o_collision      = r_collision;
    assign o_hitObjectValid = r_hit_valid;
    assign o_hitObjectIdx   = r_hit_idx;
    assign o_collectedMask  = r_mask;
    assign o_collectPulse   = r_collect_pulse;
    assign o_collectIdx     = r_collect_idx;
endmodule

// File: tb/tb_hook_collision_detector.sv
// tb_hook_collision_detector: directed scenarios checked against a queued spec-level expectation per cycle
module tb_hook_collision_detector;
    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       launch_Cable;
    logic       cableHome;
    logic       dr_hook;
    logic [7:0] dr_objects;
    logic       dr_border;
    logic       collision;
    logic       hitObjectValid;
    logic [2:0] hitObjectIdx;
    logic [7:0] collectedMask;
    logic       collectPulse;
    logic [2:0] collectIdx;

    typedef struct {
        logic       coll;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] mask;
        logic       pulse;
        logic [2:0] cidx;
        logic       rst;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = 0;
    int   m_cnt = 0;
    logic m_valid = 0;
    logic [2:0] m_idx = 0;
    logic [7:0] m_mask = 0;

    hook_collision_detector dut (
        .i_clk                    (clk),
        .i_reset                  (reset),
        .i_startOfFrame           (startOfFrame),
        .i_launch_Cable           (launch_Cable),
        .i_cableHome              (cableHome),
        .i_drawingRequest_hook    (dr_hook),
        .i_drawingRequest_objects (dr_objects),
        .i_drawingRequest_border  (dr_border),
        .o_collision              (collision),
        .o_hitObjectValid         (hitObjectValid),
        .o_hitObjectIdx           (hitObjectIdx),
        .o_collectedMask          (collectedMask),
        .o_collectPulse           (collectPulse),
        .o_collectIdx             (collectIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic launch, input logic home, input logic sof,
                        input logic hook, input logic border, input logic [7:0] obj);
        exp_t e;
        logic [7:0] eff;
        reset = rst; launch_Cable = launch; cableHome = home; startOfFrame = sof;
        dr_hook = hook; dr_border = border; dr_objects = obj;
        e.coll = 0; e.pulse = 0; e.cidx = 0; e.rst = rst;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_valid = 0; m_idx = 0; m_mask = 0;
        end else if (m_state == 0) begin
            if (launch) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            eff = obj & ~m_mask;
            if (hook && eff != 0) begin
                for (int k = 0; k < 8; k++) if (eff[k]) begin m_idx = 3'(k); break; end
                m_valid = 1; e.coll = 1; m_state = 2;
            end else if (hook && border) begin
                m_valid = 0; e.coll = 1; m_state = 2;
            end else if (sof) begin
                if (m_cnt == 89) begin m_valid = 0; e.coll = 1; m_state = 2; end
                else m_cnt++;
            end
        end else if (home) begin
            if (m_valid) begin e.pulse = 1; e.cidx = m_idx; m_mask[m_idx] = 1'b1; m_valid = 0; end
            m_state = 0;
        end
        e.valid = m_valid; e.idx = m_idx; e.mask = m_mask;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("collision", collision, e.coll);
        chk("hitObjectValid", hitObjectValid, e.valid);
        chk("hitObjectIdx", hitObjectIdx, e.idx);
        chk("collectedMask", collectedMask, e.mask);
        chk("collectPulse", collectPulse, e.pulse);
        if (e.pulse || e.rst) chk("collectIdx", collectIdx, e.cidx);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        reset = 1; launch_Cable = 0; cableHome = 0; startOfFrame = 0;
        dr_hook = 0; dr_border = 0; dr_objects = 0;
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("reset_mask", collectedMask, 8'h00);
        // IDLE overlaps are ignored
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 0, 8'h08);
        chk("idle_no_collision", collision, 1'b0);
        // launch, then two objects overlap: lowest index wins, single pulse
        step(0, 1, 0, 0, 0, 0, 8'h00);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 8'h24);
        chk("hit_coll", collision, 1'b1);
        chk("hit_idx", hitObjectIdx, 3'd2);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 1, 1, 8'h24);
        // home delivers object 2
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("collect_idx", collectIdx, 3'd2);
        chk("mask_after_collect", collectedMask, 8'h04);
        idle(2);
        // relaunch: collected object is masked, border hit instead
        step(0, 1, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 8'h04);
        step(0, 0, 0, 0, 1, 1, 8'h04);
        chk("border_coll", collision, 1'b1);
        idle(2);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        idle(1);
        // timeout: 89 frames quiet, the 90th forces the pulse
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 89; k++) begin
            step(0, 0, 0, 1, 0, 0, 8'h00);
            step(0, 0, 0, 0, 0, 0, 8'h00);
        end
        chk("timeout_89_none", collision, 1'b0);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        chk("timeout_90_coll", collision, 1'b1);
        idle(1);
        // home and launch together while HOOKED: launch dropped
        step(0, 1, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h01);
        // object 7 then home, object 1 hit then reset before home
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h80);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("mask_two", collectedMask, 8'h84);
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h02);
        chk("obj1_idx", hitObjectIdx, 3'd1);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("reset_mid_mask", collectedMask, 8'h00);
        chk("reset_mid_valid", hitObjectValid, 1'b0);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("no_collect_after_reset", collectPulse, 1'b0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
